uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD, default 115200, serial bit rate in bits/s.
REQ-002 SHALL have parameter FREQ, default 50000000, clk_i frequency in Hz.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk_i  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_i  input  1  asynchronous serial line, idle high (driven by the testbench UART model TX).
REQ-007 SHALL have port data_o  output  8  received byte at FIFO head.
REQ-008 SHALL have port valid_o  output  1  FIFO non-empty.
REQ-009 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o & ready_i.
REQ-010 SHALL have port level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overflow_o  output  1  sticky, a byte was dropped because the FIFO was full.
REQ-013 SHALL have port clear_i  input  1  clears overflow_o (and parity_err_o) next cycle.

Function
REQ-014 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-015 SHALL use CPB = FREQ/BAUD (integer division) cycles per bit; elaboration SHALL fail if CPB < 4.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK; reset state IDLE.
REQ-017 IDLE->START when synchronized line is 0; bit-cycle counter cleared.
REQ-018 START: at counter == CPB/2-1 sample; 1 -> IDLE (false start, nothing reported); 0 -> DATA, counter and bit index cleared.
REQ-019 DATA: at counter == CPB-1 sample into bit[index], LSB first; after index 7 -> STOP.
REQ-020 STOP: at counter == CPB-1 sample; 1 -> push byte, go IDLE; 0 -> pulse frame_err_o, discard byte, go BREAK.
REQ-021 BREAK: stay until synchronized line is 1, then IDLE (no restart on a held-low line).
REQ-022 Push SHALL make valid_o/data_o visible the cycle after the stop sample when FIFO was empty.
REQ-023 Pop SHALL occur on the clk_i edge where valid_o & ready_i; data_o SHALL be stable while valid_o & !ready_i.
REQ-024 Push when full without simultaneous pop SHALL drop the byte and set overflow_o; push with simultaneous pop when full SHALL be accepted, level_o unchanged.
REQ-025 Simultaneous push and pop when non-full, non-empty SHALL leave level_o unchanged.
REQ-026 clear_i together with a new overflow event SHALL leave overflow_o set.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level_o ranges 0..FIFO_DEPTH.

Reset
REQ-028 rst_i SHALL force: FSM IDLE, FIFO empty, valid_o=0, level_o=0, data_o=0, frame_err_o=0, overflow_o=0, synchronizer flops=1.
REQ-029 rst_i asserted mid-frame SHALL abandon the partial byte; after release, reception SHALL restart only on a new falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: SHALL add state PARITY between DATA and STOP, sample even parity at CPB-1, and add output parity_err_o (1 bit, sticky, cleared by clear_i); a byte with bad parity SHALL still be pushed.
REQ-031 Macro undefined: SHALL use a 10-bit frame (start, 8 data, stop), no PARITY state, and no parity_err_o port.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, the byte typedef, and function cycles_per_bit(FREQ, BAUD).
REQ-033 The FIFO SHALL be sub-module uart_rx_fifo (sync, parameterized depth and width, push/pop/full/empty/level); uart_rx SHALL contain synchronizer, FSM and flags.

Verification
REQ-034 FREQ=800, BAUD=100 (CPB=8), send 0xA5 -> one valid_o with data_o=0xA5, level_o=1, no flags.
REQ-035 Send 0x00, 0xFF, 0x3C back-to-back, ready_i=1 -> three accepted bytes in that order, level_o back to 0.
REQ-036 Low glitch of 3 cycles on rx_i -> FSM returns to IDLE, no valid_o, no frame_err_o.
REQ-037 Send 0x55 with stop bit 0 held low for 40 cycles -> single frame_err_o pulse, no push, next 0x12 received correctly.
REQ-038 ready_i=0, send FIFO_DEPTH+1 bytes -> level_o=8, overflow_o=1, first 8 bytes retained; clear_i -> overflow_o=0.
REQ-039 Assert rst_i after data bit 3 of 0x81 -> no output; next frame 0x7E received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding, byte type, bit timing.
// UART_RX_PARITY_EN adds the PARITY state for the even-parity frame variant.
package uart_pkg;

    typedef logic [7:0] byte_t;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4,
        S_PARITY = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;
`endif

    function automatic int cycles_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte stream carrying received data from the FIFO head.
// The master drives data/valid, the slave drives ready.
interface uart_rx_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes; head is presented on a valid/ready stream.
// A write while full is accepted only when a pop happens on the same edge.
module uart_rx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    uart_rx_if.master     out_if,
    output logic          full_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] cnt_q;
    logic          empty;
    logic          pop;
    logic          wr_en;

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign pop     = out_if.ready & ~empty;
    assign wr_en   = push_i & (~full_o | pop);
    assign level_o = cnt_q;

    assign out_if.valid = ~empty;
    assign out_if.data  = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, receive FIFO, sticky flags.
// UART_RX_PARITY_EN selects an 11-bit frame with even parity and parity_err_o.
module uart_rx
    import uart_pkg::*;
#(
    parameter  int BAUD       = 115200,
    parameter  int FREQ       = 50000000,
    parameter  int FIFO_DEPTH = 8,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [LW-1:0] level_o,
    output logic          frame_err_o,
    output logic          overflow_o,
`ifdef UART_RX_PARITY_EN
    output logic          parity_err_o,
`endif
    input  logic          clear_i
);

    localparam int CPB = cycles_per_bit(FREQ, BAUD);
    localparam int CW  = $clog2(CPB);

    generate
        if (CPB < 4) begin : g_cpb_chk
            $error("uart_rx: FREQ/BAUD must be at least 4");
        end
    endgenerate

    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    logic [1:0]    sync_q;
    logic [1:0]    vld_q;
    logic          rx_s;
    logic          armed_q, armed_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    byte_t         sh_q, sh_d;
    logic          ferr_q, ferr_d;
    logic          ov_q, ov_d;
    logic          push;
    logic          pop;
    logic          drop;
    logic          fifo_full;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          par_bad;
`endif

    uart_rx_if #(.W(8)) q_if ();

    assign rx_s       = sync_q[1];
    assign q_if.ready = ready_i;
    assign data_o     = q_if.data;
    assign valid_o    = q_if.valid;
    assign pop        = q_if.valid & ready_i;
    assign drop       = push & fifo_full & ~pop;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (sh_q),
        .out_if  (q_if),
        .full_o  (fifo_full),
        .level_o (level_o)
    );

    // A start bit is only accepted once a genuine idle-high line has been
    // seen after reset, so a line still low from an abandoned frame is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        armed_d = armed_q | (vld_q[1] & rx_s);
`ifdef UART_RX_PARITY_EN
        par_bad = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    idx_d = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = S_PARITY;
`else
                    if (idx_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_bad = ^{sh_q, rx_s};
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ov_d = (ov_q & ~clear_i) | drop;
`ifdef UART_RX_PARITY_EN
    assign par_d        = (par_q & ~clear_i) | par_bad;
    assign parity_err_o = par_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            ferr_q  <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            ferr_q  <= ferr_d;
            ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign frame_err_o = ferr_q;
    assign overflow_o  = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus random-byte bench for uart_rx at CPB=8 with an 8-entry FIFO.
// A serial line model drives rx_i; a byte queue is the reference.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 8;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          clear;
    logic [LW-1:0] level;
    logic          ferr;
    logic          ov;
`ifdef UART_RX_PARITY_EN
    logic          perr;
`endif

    uart_rx_if #(.W(8)) bus ();

    uart_rx #(
        .BAUD       (100),
        .FREQ       (800),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .data_o       (bus.data),
        .valid_o      (bus.valid),
        .ready_i      (bus.ready),
        .level_o      (level),
        .frame_err_o  (ferr),
        .overflow_o   (ov),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (perr),
`endif
        .clear_i      (clear)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    ferr_n = 0;
    byte_t got[$];
    byte_t exp_q[$];

    // Record every accepted byte and every frame error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid && bus.ready) got.push_back(bus.data);
            if (ferr) ferr_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input byte_t b, input logic stop_v = 1'b1,
                        input int stop_n = CPB, input int rst_bit = -1);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
                tick(CPB - 2);
            end else begin
                tick(CPB);
            end
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b;
        tick(CPB);
`endif
        rx = stop_v;
        tick(stop_n);
        rx = 1'b1;
    endtask

    initial begin
        byte_t b;
        int    base;
        rst       = 1'b1;
        rx        = 1'b1;
        clear     = 1'b0;
        bus.ready = 1'b0;
        tick(3);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        rst = 1'b0;
        tick(4);

        send(8'hA5);
        tick(2);
        chk("a5_valid", 32'(bus.valid), 32'd1);
        chk("a5_data", 32'(bus.data), 32'hA5);
        chk("a5_level", 32'(level), 32'd1);
        chk("a5_ferr", 32'(ferr_n), 32'd0);
        chk("a5_ov", 32'(ov), 32'd0);
        bus.ready = 1'b1;
        tick(2);
        got.delete();

        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        tick(3);
        chk("b2b_n", 32'(got.size()), 32'd3);
        chk("b2b_0", 32'(got[0]), 32'h00);
        chk("b2b_1", 32'(got[1]), 32'hFF);
        chk("b2b_2", 32'(got[2]), 32'h3C);
        chk("b2b_level", 32'(level), 32'd0);

        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * CPB);
        chk("glitch_push", 32'(got.size()), 32'd3);
        chk("glitch_ferr", 32'(ferr_n), 32'd0);

        send(8'h55, 1'b0, 40);
        tick(4);
        chk("ferr_pulse", 32'(ferr_n), 32'd1);
        chk("ferr_push", 32'(got.size()), 32'd3);
        send(8'h12);
        tick(3);
        chk("ferr_next_n", 32'(got.size()), 32'd4);
        chk("ferr_next", 32'(got[3]), 32'h12);
        chk("ferr_once", 32'(ferr_n), 32'd1);

        bus.ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            b = byte_t'($urandom);
            exp_q.push_back(b);
            send(b);
        end
        tick(2);
        chk("ovf_level", 32'(level), 32'(DEPTH));
        chk("ovf_flag", 32'(ov), 32'd1);
        chk("ovf_head", 32'(bus.data), 32'(exp_q[0]));
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("ovf_clear", 32'(ov), 32'd0);
        base = got.size();
        bus.ready = 1'b1;
        tick(DEPTH + 2);
        chk("ovf_n", 32'(got.size() - base), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("ovf_b%0d", i), 32'(got[base + i]), 32'(exp_q[i]));
        chk("ovf_empty", 32'(level), 32'd0);

        base = got.size();
        send(8'h81, 1'b1, CPB, 4);
        tick(3 * CPB);
        chk("rst_mid_n", 32'(got.size() - base), 32'd0);
        chk("rst_mid_lvl", 32'(level), 32'd0);
        send(8'h7E);
        tick(3);
        chk("rst_next_n", 32'(got.size() - base), 32'd1);
        chk("rst_next", 32'(got[base]), 32'h7E);

        base = got.size();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            b = byte_t'($urandom);
            exp_q.push_back(b);
            send(b);
            tick($urandom_range(0, 5));
        end
        tick(3);
        chk("rand_n", 32'(got.size() - base), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rand_b%0d", i), 32'(got[base + i]), 32'(exp_q[i]));
        chk("rand_ferr", 32'(ferr_n), 32'd1);
        chk("rand_ov", 32'(ov), 32'd0);
`ifdef UART_RX_PARITY_EN
        chk("parity_ok", 32'(perr), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
